// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT write-data receiver: FSM encoding, CRC
// status tokens, inter-phase gap length and the CRC16 polynomial/step helper.
package sd_dat_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    DATA       = 3'd2,
    CRC        = 3'd3,
    END        = 3'd4,
    GAP        = 3'd5,
    TOKEN      = 3'd6,
    BUSY       = 3'd7
  } dat_state_e;

  localparam logic [2:0]  TOK_OK      = 3'b010;
  localparam logic [2:0]  TOK_CRC_ERR = 3'b101;
  localparam logic [2:0]  TOK_END_ERR = 3'b110;
  localparam int          GAP_LEN     = 2;
  localparam int          CRC_LEN     = 16;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;

  // One serial CRC16 step; feeding message then its CRC leaves a zero residue.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial 1-bit CRC16 (x^16+x^12+x^5+1) with synchronous clear and enable.
// Only compiled when SD_DAT_CRC_CHECK_EN is defined.
`ifdef SD_DAT_CRC_CHECK_EN
module sd_crc16
  import sd_dat_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  // CRC shift register, cleared per block
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      crc_q <= 16'h0000;
    end else if (en_i) begin
      crc_q <= crc16_step(crc_q, bit_i);
    end else begin
      crc_q <= crc_q;
    end
  end

  assign crc_o = crc_q;

endmodule
`endif

// File: rtl/sd_card_dat_rx.sv
// SD card-side 4-bit DAT write receiver: start bit, data, per-line CRC16, end bit,
// CRC status token and busy signalling. Macro SD_DAT_CRC_CHECK_EN enables CRC checking.
module sd_card_dat_rx
  import sd_dat_pkg::*;
#(
  parameter int BUSY_CYCLES   = 8,
  parameter int START_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        stop,
  input  logic [9:0]  block_len,
  input  logic [10:0] block_count,
  input  logic [3:0]  dat_in,
  output logic [3:0]  dat_out,
  output logic        dat_oe,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        block_done,
  output logic        done,
  output logic [2:0]  status,
  output logic        timeout
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] BUSY_LAST    = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] BUSY_PRE     = 16'(BUSY_CYCLES - 2);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_LEN - 1);
  localparam logic [15:0] CRC_LAST     = 16'(CRC_LEN - 1);
  localparam logic        BUSY_ONE     = (BUSY_CYCLES == 1);

  dat_state_e  state_q;
  logic [15:0] cnt_q;
  logic [10:0] nib_total_q;
  logic [10:0] count_q;
  logic [10:0] blk_q;
  logic [3:0]  hi_q;
  logic [2:0]  tok_q;
  logic [7:0]  byte_data_q;
  logic        byte_valid_q;
  logic        block_done_q;
  logic        done_q;
  logic [2:0]  status_q;
  logic        timeout_q;
  logic        dat_oe_q;
  logic        dat0_q;

  logic        crc_bad_s;
  logic [2:0]  tok_d;
  logic [4:0]  tok_seq_s;
  logic        final_s;

`ifdef SD_DAT_CRC_CHECK_EN
  logic [15:0] crc_s [4];
  logic        crc_clr_s;
  logic        crc_en_s;

  assign crc_clr_s = (state_q == WAIT_START);
  assign crc_en_s  = (state_q == DATA) || (state_q == CRC);

  for (genvar g = 0; g < 4; g++) begin : g_crc
    sd_crc16 u_crc (
      .clk     (clk),
      .reset   (reset),
      .clear_i (crc_clr_s),
      .en_i    (crc_en_s),
      .bit_i   (dat_in[g]),
      .crc_o   (crc_s[g])
    );
  end

  // Data followed by a correct CRC leaves every engine at zero.
  assign crc_bad_s = |{crc_s[0], crc_s[1], crc_s[2], crc_s[3]};
`else
  assign crc_bad_s = 1'b0;
`endif

  // End-bit error outranks CRC error
  always_comb begin
    tok_d = TOK_OK;
    if (dat_in != 4'b1111) begin
      tok_d = TOK_END_ERR;
    end else if (crc_bad_s) begin
      tok_d = TOK_CRC_ERR;
    end else begin
      tok_d = TOK_OK;
    end
  end

  assign tok_seq_s = {1'b0, status_q, 1'b1};
  assign final_s   = (count_q != 11'd0) && (blk_q == count_q);

  // Receive FSM; outputs are registered for the cycle the next state occupies
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      nib_total_q  <= 11'd0;
      count_q      <= 11'd0;
      blk_q        <= 11'd0;
      hi_q         <= 4'd0;
      tok_q        <= 3'd0;
      byte_data_q  <= 8'd0;
      byte_valid_q <= 1'b0;
      block_done_q <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= 3'b000;
      timeout_q    <= 1'b0;
      dat_oe_q     <= 1'b0;
      dat0_q       <= 1'b1;
    end else begin
      byte_valid_q <= 1'b0;
      block_done_q <= 1'b0;
      done_q       <= 1'b0;
      dat_oe_q     <= 1'b0;
      dat0_q       <= 1'b1;
      if (stop) begin
        state_q <= IDLE;
        cnt_q   <= 16'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (arm) begin
              nib_total_q <= (block_len == 10'd0) ? 11'd1024 : {block_len, 1'b0};
              count_q     <= block_count;
              blk_q       <= 11'd0;
              timeout_q   <= 1'b0;
              cnt_q       <= 16'd0;
              state_q     <= WAIT_START;
            end
          end
          WAIT_START: begin
            if (dat_in == 4'b0000) begin
              cnt_q   <= 16'd0;
              state_q <= DATA;
            end else if (cnt_q == TIMEOUT_LAST) begin
              timeout_q <= 1'b1;
              cnt_q     <= 16'd0;
              state_q   <= IDLE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          DATA: begin
            if (!cnt_q[0]) begin
              hi_q <= dat_in;
            end else begin
              byte_data_q  <= {hi_q, dat_in};
              byte_valid_q <= 1'b1;
            end
            if (cnt_q[10:0] == nib_total_q - 11'd1) begin
              cnt_q   <= 16'd0;
              state_q <= CRC;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          CRC: begin
            if (cnt_q == CRC_LAST) begin
              cnt_q   <= 16'd0;
              state_q <= END;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          END: begin
            tok_q   <= tok_d;
            cnt_q   <= 16'd0;
            state_q <= GAP;
            if (blk_q != 11'h7FF) begin
              blk_q <= blk_q + 11'd1;
            end
          end
          GAP: begin
            if (cnt_q == GAP_LAST) begin
              dat_oe_q <= 1'b1;
              dat0_q   <= 1'b0;
              status_q <= tok_q;
              cnt_q    <= 16'd0;
              state_q  <= TOKEN;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          TOKEN: begin
            dat_oe_q <= 1'b1;
            if (cnt_q == 16'd4) begin
              dat0_q       <= 1'b0;
              block_done_q <= BUSY_ONE;
              done_q       <= BUSY_ONE && final_s;
              cnt_q        <= 16'd0;
              state_q      <= BUSY;
            end else begin
              dat0_q <= tok_seq_s[3'd3 - cnt_q[2:0]];
              cnt_q  <= cnt_q + 16'd1;
            end
          end
          BUSY: begin
            if (cnt_q == BUSY_LAST) begin
              cnt_q   <= 16'd0;
              state_q <= final_s ? IDLE : WAIT_START;
            end else begin
              dat_oe_q     <= 1'b1;
              dat0_q       <= 1'b0;
              block_done_q <= (cnt_q == BUSY_PRE);
              done_q       <= (cnt_q == BUSY_PRE) && final_s;
              cnt_q        <= cnt_q + 16'd1;
            end
          end
          default: begin
            cnt_q   <= 16'd0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign dat_out    = {3'b111, dat0_q | ~dat_oe_q};
  assign dat_oe     = dat_oe_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign block_done = block_done_q;
  assign done       = done_q;
  assign status     = status_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sd_card_dat_rx.sv
// Directed self-checking bench for sd_card_dat_rx (default parameters).
module tb_sd_card_dat_rx;

  localparam int BUSY_N = 8;

  logic        clk = 1'b0;
  logic        reset, arm, stop;
  logic [9:0]  block_len;
  logic [10:0] block_count;
  logic [3:0]  dat_in;
  logic [3:0]  dat_out;
  logic        dat_oe;
  logic [7:0]  byte_data;
  logic        byte_valid, block_done, done, timeout;
  logic [2:0]  status;

  int n_assert = 0;
  int n_fail   = 0;
  int bv_cnt = 0, bd_cnt = 0, dn_cnt = 0, oe_cnt = 0;
  logic [7:0] pay [512];

  always #5 clk = ~clk;

  sd_card_dat_rx dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop),
    .block_len(block_len), .block_count(block_count), .dat_in(dat_in),
    .dat_out(dat_out), .dat_oe(dat_oe), .byte_data(byte_data),
    .byte_valid(byte_valid), .block_done(block_done), .done(done),
    .status(status), .timeout(timeout)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid) bv_cnt++;
      if (block_done) bd_cnt++;
      if (done) dn_cnt++;
      if (dat_oe) oe_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] line_crc(input int line, input int nbytes);
    logic [15:0] c;
    logic [7:0]  b;
    logic [3:0]  nib;
    logic        fb;
    c = 16'h0000;
    for (int j = 0; j < nbytes; j++) begin
      b = pay[j];
      for (int h = 1; h >= 0; h--) begin
        nib = (h == 1) ? b[7:4] : b[3:0];
        fb  = nib[line] ^ c[15];
        c   = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic do_arm(input logic [9:0] len, input logic [10:0] cnt);
    block_len   = len;
    block_count = cnt;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Start bit, payload, CRC, end bit, then the two GAP cycles
  task automatic run_block(input int nbytes, input logic [3:0] end_nib, input bit flip2);
    logic [15:0] crc [4];
    for (int l = 0; l < 4; l++) crc[l] = line_crc(l, nbytes);
    if (flip2) crc[2][7] = ~crc[2][7];
    dat_in = 4'h0;
    tick();
    for (int j = 0; j < nbytes; j++) begin
      dat_in = pay[j][7:4];
      tick();
      chk("bv_hi", {15'd0, byte_valid}, 16'd0);
      dat_in = pay[j][3:0];
      tick();
      chk("bv_lo", {15'd0, byte_valid}, 16'd1);
      chk("byte", {8'd0, byte_data}, {8'd0, pay[j]});
    end
    for (int b = 15; b >= 0; b--) begin
      dat_in = {crc[3][b], crc[2][b], crc[1][b], crc[0][b]};
      tick();
    end
    chk("bv_crc_end", {15'd0, byte_valid}, 16'd0);
    dat_in = end_nib;
    tick();
    dat_in = 4'hF;
    chk("gap0_oe", {15'd0, dat_oe}, 16'd0);
    tick();
    chk("gap1_oe", {15'd0, dat_oe}, 16'd0);
    tick();
  endtask

  // Token and busy phase; stop_k >= 0 asserts stop in that busy cycle
  task automatic check_token(input logic [2:0] tok, input bit fin, input int stop_k);
    logic [4:0] seq;
    seq = {1'b0, tok, 1'b1};
    for (int k = 0; k < 5; k++) begin
      chk("tok_oe", {15'd0, dat_oe}, 16'd1);
      chk("tok_bit", {12'd0, dat_out}, {12'd0, 3'b111, seq[4-k]});
      if (k == 0) chk("status", {13'd0, status}, {13'd0, tok});
      tick();
    end
    for (int k = 0; k < BUSY_N; k++) begin
      chk("busy_oe", {15'd0, dat_oe}, 16'd1);
      chk("busy_dat", {12'd0, dat_out}, 16'h000E);
      chk("block_done", {15'd0, block_done}, {15'd0, k == BUSY_N - 1});
      chk("done", {15'd0, done}, {15'd0, fin && (k == BUSY_N - 1)});
      if (k == stop_k) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_oe", {15'd0, dat_oe}, 16'd0);
        chk("stop_dat", {12'd0, dat_out}, 16'h000F);
        chk("stop_done", {15'd0, done}, 16'd0);
        return;
      end
      tick();
    end
    chk("rel_oe", {15'd0, dat_oe}, 16'd0);
    chk("rel_dat", {12'd0, dat_out}, 16'h000F);
  endtask

  initial begin
    int bv0, bd0, dn0, oe0;
    logic [2:0] flip_exp;
`ifdef SD_DAT_CRC_CHECK_EN
    flip_exp = 3'b101;
`else
    flip_exp = 3'b010;
`endif
    reset = 1'b1; arm = 1'b0; stop = 1'b0;
    block_len = 10'd4; block_count = 11'd1; dat_in = 4'hF;
    tick();
    tick();
    chk("rst_oe", {15'd0, dat_oe}, 16'd0);
    chk("rst_dat", {12'd0, dat_out}, 16'h000F);
    chk("rst_byte", {8'd0, byte_data}, 16'd0);
    chk("rst_bv", {15'd0, byte_valid}, 16'd0);
    chk("rst_bd", {15'd0, block_done}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_status", {13'd0, status}, 16'd0);
    chk("rst_timeout", {15'd0, timeout}, 16'd0);
    reset = 1'b0;
    tick();

    // Basic 4-byte block, good CRC
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'h00; pay[3] = 8'hFF;
    bv0 = bv_cnt; dn0 = dn_cnt; bd0 = bd_cnt;
    do_arm(10'd4, 11'd1);
    run_block(4, 4'hF, 1'b0);
    check_token(3'b010, 1'b1, -1);
    chk("a_bv_count", 16'(bv_cnt - bv0), 16'd4);
    chk("a_done_count", 16'(dn_cnt - dn0), 16'd1);
    chk("a_bd_count", 16'(bd_cnt - bd0), 16'd1);

    // CRC bit flipped on DAT2
    do_arm(10'd4, 11'd1);
    run_block(4, 4'hF, 1'b1);
    check_token(flip_exp, 1'b1, -1);

    // Bad end bit, then bad end bit plus bad CRC
    do_arm(10'd4, 11'd1);
    run_block(4, 4'hE, 1'b0);
    check_token(3'b110, 1'b1, -1);
    do_arm(10'd4, 11'd1);
    run_block(4, 4'hE, 1'b1);
    check_token(3'b110, 1'b1, -1);

    // Three 512-byte blocks (block_len 0 encodes 512)
    for (int j = 0; j < 512; j++) pay[j] = 8'((j * 7 + 3) ^ (j >> 3));
    bv0 = bv_cnt; bd0 = bd_cnt; dn0 = dn_cnt;
    do_arm(10'd0, 11'd3);
    for (int b = 0; b < 3; b++) begin
      run_block(512, 4'hF, 1'b0);
      check_token(3'b010, b == 2, -1);
    end
    chk("big_bv_count", 16'(bv_cnt - bv0), 16'd1536);
    chk("big_bd_count", 16'(bd_cnt - bd0), 16'd3);
    chk("big_done_count", 16'(dn_cnt - dn0), 16'd1);

    // Start-bit timeout
    pay[0] = 8'h5A;
    oe0 = oe_cnt;
    do_arm(10'd1, 11'd1);
    dat_in = 4'hF;
    for (int i = 0; i < 254; i++) tick();
    chk("to_early", {15'd0, timeout}, 16'd0);
    tick();
    chk("to_set", {15'd0, timeout}, 16'd1);
    chk("to_no_oe", 16'(oe_cnt - oe0), 16'd0);
    bv0 = bv_cnt;
    dat_in = 4'h0;
    for (int i = 0; i < 6; i++) tick();
    dat_in = 4'hF;
    chk("to_idle_no_bv", 16'(bv_cnt - bv0), 16'd0);
    chk("to_sticky", {15'd0, timeout}, 16'd1);

    // Stop in third busy cycle, then a clean restart
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'h00; pay[3] = 8'hFF;
    dn0 = dn_cnt; bd0 = bd_cnt;
    do_arm(10'd4, 11'd1);
    chk("arm_clr_to", {15'd0, timeout}, 16'd0);
    run_block(4, 4'hF, 1'b0);
    check_token(3'b010, 1'b1, 2);
    for (int i = 0; i < 10; i++) tick();
    chk("stop_no_done", 16'(dn_cnt - dn0), 16'd0);
    chk("stop_no_bd", 16'(bd_cnt - bd0), 16'd0);
    do_arm(10'd4, 11'd1);
    run_block(4, 4'hF, 1'b0);
    check_token(3'b010, 1'b1, -1);
    chk("restart_done", 16'(dn_cnt - dn0), 16'd1);

    // Stop and arm in the same cycle: stop wins
    bv0 = bv_cnt;
    block_len = 10'd1; block_count = 11'd1;
    arm = 1'b1; stop = 1'b1;
    tick();
    arm = 1'b0; stop = 1'b0;
    dat_in = 4'h0;
    for (int i = 0; i < 6; i++) tick();
    dat_in = 4'hF;
    chk("stop_arm_no_bv", 16'(bv_cnt - bv0), 16'd0);

    // Open-ended mode: blocks keep coming until stop
    pay[0] = 8'h5A;
    dn0 = dn_cnt; bd0 = bd_cnt;
    do_arm(10'd1, 11'd0);
    run_block(1, 4'hF, 1'b0);
    check_token(3'b010, 1'b0, -1);
    run_block(1, 4'hF, 1'b0);
    check_token(3'b010, 1'b0, -1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("open_bd_count", 16'(bd_cnt - bd0), 16'd2);
    chk("open_no_done", 16'(dn_cnt - dn0), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
